// File: rtl/hilo_muldiv_pkg.sv
// Shared state encoding, divide special-case constants and the sign helper
// for the HI/LO multiply/divide unit.
package hilo_muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [31:0] DIV_ZERO_LO      = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
    localparam logic [31:0] DIV_OVF_LO       = 32'h8000_0000;
    localparam logic [31:0] DIV_OVF_HI       = 32'h0000_0000;
    localparam logic [4:0]  DIV_STEP_FIRST   = 5'd31;

    function automatic logic [31:0] cond_neg(input logic [31:0] x, input logic neg);
        return neg ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/hilo_muldiv_div_radix2.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per cycle,
// step counter runs 31..0 and done marks the final step.
module div_radix2
    import hilo_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cancel,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);

    logic [31:0] dsr;
    logic [4:0]  cnt;
    logic        busy;
    logic [32:0] rem_sh;
    logic [32:0] diff;

    // The dividend shifts out of the quotient register as quotient bits shift in.
    assign rem_sh = {remainder, quotient[31]};
    assign diff   = rem_sh - {1'b0, dsr};
    assign done   = busy & (cnt == 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quotient  <= '0;
            remainder <= '0;
            dsr       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
        end else if (cancel) begin
            busy <= 1'b0;
        end else if (start) begin
            quotient  <= dividend;
            remainder <= '0;
            dsr       <= divisor;
            cnt       <= DIV_STEP_FIRST;
            busy      <= 1'b1;
        end else if (busy) begin
            if (!diff[32]) begin
                remainder <= diff[31:0];
                quotient  <= {quotient[30:0], 1'b1};
            end else begin
                remainder <= rem_sh[31:0];
                quotient  <= {quotient[30:0], 1'b0};
            end
            cnt <= cnt - 5'd1;
            if (cnt == 5'd0)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// EX-stage HI/LO unit: MULT/MULTU/MUL/DIV/DIVU/MTHI/MTLO, owns HI/LO and
// stalls EX while a multi-cycle operation is in flight.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic        flush,
    input  logic        is_mult,
    input  logic        is_multu,
    input  logic        is_div,
    input  logic        is_divu,
    input  logic        hi_wen,
    input  logic        lo_wen,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] product
);

    state_t             state, state_nxt;
    logic               req, accept, is_mul_req, signed_req;
    logic signed [32:0] op_a, op_b;
    logic               mul_q, sgn_q;
    logic [2:0]         mul_cnt;
    logic signed [63:0] mul_full;
    logic signed [63:0] prod_p [MUL_CYCLES];
    logic               div_start, div_done;
    logic [31:0]        div_quo, div_rem, mag_a, mag_b;
    logic [63:0]        div_res, result;

    assign is_mul_req = is_mult | is_multu;
    assign signed_req = is_mult | is_div;
    assign req        = valid & (is_mult | is_multu | is_div | is_divu);
    assign accept     = (state == ST_IDLE) & req & ~flush;
    assign stall      = req & (state != ST_DONE) & ~flush;
    assign div_start  = accept & ~is_mul_req;
    assign mag_a      = cond_neg(rs_data, is_div & rs_data[31]);
    assign mag_b      = cond_neg(rt_data, is_div & rt_data[31]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a    <= '0;
            op_b    <= '0;
            mul_q   <= 1'b0;
            sgn_q   <= 1'b0;
            mul_cnt <= '0;
        end else if (accept) begin
            op_a    <= {signed_req & rs_data[31], rs_data};
            op_b    <= {signed_req & rt_data[31], rt_data};
            mul_q   <= is_mul_req;
            sgn_q   <= signed_req;
            mul_cnt <= '0;
        end else if (state == ST_MUL) begin
            mul_cnt <= mul_cnt + 3'd1;
        end
    end

    // Multiplier pipeline: product of the latched 33-bit operands, MUL_CYCLES deep.
    assign mul_full = 64'(op_a) * 64'(op_b);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MUL_CYCLES; i++)
                prod_p[i] <= '0;
        end else begin
            prod_p[0] <= mul_full;
            for (int i = 1; i < MUL_CYCLES; i++)
                prod_p[i] <= prod_p[i-1];
        end
    end

    div_radix2 u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .cancel    (flush),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    // Sign fix and special cases on the magnitude result.
    always_comb begin
        div_res = {cond_neg(div_rem, sgn_q & op_a[31]),
                   cond_neg(div_quo, sgn_q & (op_a[31] ^ op_b[31]))};
        if (op_b[31:0] == 32'd0)
            div_res = {op_a[31:0], DIV_ZERO_LO};
        else if (sgn_q && op_a[31:0] == DIV_OVF_DIVIDEND && op_b[31:0] == 32'hFFFF_FFFF)
            div_res = {DIV_OVF_HI, DIV_OVF_LO};
    end

    assign result  = mul_q ? prod_p[MUL_CYCLES-1] : div_res;
    assign product = (state == ST_DONE) ? result[31:0] : 32'd0;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = is_mul_req ? ST_MUL : ST_DIV;
            ST_MUL: begin
                if (flush)
                    state_nxt = ST_IDLE;
                else if (mul_cnt == 3'(MUL_CYCLES - 1))
                    state_nxt = ST_DONE;
            end
            ST_DIV: begin
                if (flush)
                    state_nxt = ST_IDLE;
                else if (div_done)
                    state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state == ST_DONE) begin
            if (!flush) begin
                hi <= result[63:32];
                lo <= result[31:0];
            end
        end else if (state == ST_IDLE && valid && !flush) begin
            if (hi_wen) hi <= rs_data;
            if (lo_wen) lo <= rs_data;
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomised and directed bench for hilo_muldiv against an arithmetic
// reference model of HI/LO results and stall latency.
module tb_hilo_muldiv;

    localparam int MUL_CYCLES = 2;
    localparam int OP_MULT = 0, OP_MULTU = 1, OP_MUL = 2, OP_DIV = 3,
                   OP_DIVU = 4, OP_MTHI = 5, OP_MTLO = 6;

    logic        clk = 1'b0;
    logic        reset, valid, flush;
    logic        is_mult, is_multu, is_div, is_divu, hi_wen, lo_wen;
    logic [31:0] rs_data, rt_data;
    logic        stall;
    logic [31:0] hi, lo, product;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] m_hi, m_lo;
    int          lat;

    always #5 clk = ~clk;

    hilo_muldiv #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid    (valid),
        .flush    (flush),
        .is_mult  (is_mult),
        .is_multu (is_multu),
        .is_div   (is_div),
        .is_divu  (is_divu),
        .hi_wen   (hi_wen),
        .lo_wen   (lo_wen),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo),
        .product  (product)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sp;
        case (op)
            OP_MULT, OP_MUL: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            end
            OP_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return {m_hi, m_lo};
        endcase
    endfunction

    task automatic clear_inputs();
        valid = 1'b0; flush = 1'b0;
        is_mult = 1'b0; is_multu = 1'b0; is_div = 1'b0; is_divu = 1'b0;
        hi_wen = 1'b0; lo_wen = 1'b0;
    endtask

    task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b);
        clear_inputs();
        valid    = 1'b1;
        rs_data  = a;
        rt_data  = b;
        is_mult  = (op == OP_MULT) || (op == OP_MUL);
        is_multu = (op == OP_MULTU);
        is_div   = (op == OP_DIV);
        is_divu  = (op == OP_DIVU);
        hi_wen   = (op == OP_MTHI);
        lo_wen   = (op == OP_MTLO);
    endtask

    // Counts stall-high cycles; returns in the first cycle with stall low.
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
        end
    endtask

    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int n;
        issue(op, a, b);
        if (op == OP_MTHI || op == OP_MTLO) begin
            @(negedge clk);
            check("mt_stall", 64'(stall), 64'd0);
            @(posedge clk); #1;
            clear_inputs();
            if (op == OP_MTHI) m_hi = a; else m_lo = a;
        end else begin
            exp = model(op, a, b);
            wait_done(n);
            check("latency", 64'(n), (op <= OP_MUL) ? 64'(1 + MUL_CYCLES) : 64'd33);
            if (op == OP_MUL) check("product", 64'(product), 64'(exp[31:0]));
            @(posedge clk); #1;
            clear_inputs();
            {m_hi, m_lo} = exp;
        end
        check("hi", 64'(hi), 64'(m_hi));
        check("lo", 64'(lo), 64'(m_lo));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end by 2000000");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b;
        int op;
        clear_inputs();
        rs_data = '0; rt_data = '0;
        reset = 1'b1;
        m_hi = '0; m_lo = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_product", 64'(product), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        check("mult_hi_const", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo_const", 64'(lo), 64'hFFFF_FFFA);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_hi_const", 64'(hi), 64'hFFFF_FFFE);
        run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_lo_const", 64'(lo), 64'hFFFF_FFFD);
        check("div_hi_const", 64'(hi), 64'hFFFF_FFFF);
        run_op(OP_DIVU, 32'd100, 32'd7);
        check("divu_lo_const", 64'(lo), 64'd14);
        run_op(OP_DIVU, 32'd5, 32'd0);
        check("divz_hi_const", 64'(hi), 64'd5);
        run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("ovf_lo_const", 64'(lo), 64'h8000_0000);
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE);

        // Flush mid-divide: stall drops at once, HI/LO untouched, unit back in IDLE.
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        #1 check("flush_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        clear_inputs();
        check("flush_hi", 64'(hi), 64'(m_hi));
        check("flush_lo", 64'(lo), 64'(m_lo));
        run_op(OP_MTLO, 32'hCAFE_0001, 32'd0);

        // Flush in the DONE cycle suppresses the write.
        issue(OP_MULT, 32'd7, 32'd9);
        wait_done(lat);
        flush = 1'b1;
        @(posedge clk); #1;
        clear_inputs();
        check("flush_done_hi", 64'(hi), 64'(m_hi));
        check("flush_done_lo", 64'(lo), 64'(m_lo));

        // Asynchronous reset mid-divide.
        run_op(OP_MTHI, 32'h5555_AAAA, 32'd0);
        issue(OP_DIV, 32'd12345, 32'd67);
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        @(posedge clk); #1;
        clear_inputs();
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        #1 check("arst_stall", 64'(stall), 64'd0);

        // MTLO followed immediately by MULT.
        issue(OP_MTLO, 32'h0000_1234, 32'd0);
        @(posedge clk); #1;
        check("mtlo_then_mult_lo", 64'(lo), 64'h1234);
        m_lo = 32'h1234;
        run_op(OP_MULT, 32'd5, 32'd6);
        check("mult_after_mtlo_lo", 64'(lo), 64'd30);

        // Back-to-back DIVU: second op presented in the cycle after DONE.
        issue(OP_DIVU, 32'd1000, 32'd7);
        wait_done(lat);
        check("b2b_lat1", 64'(lat), 64'd33);
        @(posedge clk); #1;
        {m_hi, m_lo} = model(OP_DIVU, 32'd1000, 32'd7);
        check("b2b_first_lo", 64'(lo), 64'(m_lo));
        run_op(OP_DIVU, 32'd999, 32'd10);

        for (int k = 0; k < 40; k++) begin
            op = $urandom_range(0, 6);
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 31);
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 15) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            run_op(op, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
